// File: rtl/cache_fill_arbiter.sv
// Arbitrates ICACHE/DCACHE block refills onto the shared main memory and sequences word issue/return.
// Optional: define CACHE_FILL_CRITICAL_FIRST_EN for critical-word-first issue order and early_word_valid.
module cache_fill_arbiter #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss_req,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss_req,
    input  logic [ADDR_W-1:0] d_miss_addr,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              fill_we_i,
    output logic              fill_we_d,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_idx,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_done_i,
    output logic              fill_done_d,
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
    output logic              early_word_valid,
`endif
    output logic              ICACHE_miss,
    output logic              DCACHE_miss
);

    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
    localparam int OFF_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                  state;
    logic                    owner_i;
    logic                    owner_d;
    logic [IDX_W-1:0]        issue_cnt;
    logic [IDX_W-1:0]        recv_cnt;
    logic [ADDR_W-OFF_W-1:0] base_hi;
    logic [IDX_W-1:0]        start_idx;
    logic [IDX_W-1:0]        next_issue;
    logic [ADDR_W-1:0]       grant_addr;
    logic [IDX_W-1:0]        grant_first;
    logic                    active;
    logic                    grant_ok;
    logic                    unused_addr_bits;

    assign active     = (state != IDLE);
    assign next_issue = issue_cnt + ONE_IDX;
    // No re-arbitration while a done pulse is out: the finished requester has not dropped its request yet.
    assign grant_ok   = !fill_done_i && !fill_done_d && (d_miss_req || i_miss_req);

    always_comb begin
        grant_addr = i_miss_addr;
        if (d_miss_req)
            grant_addr = d_miss_addr;
    end

`ifdef CACHE_FILL_CRITICAL_FIRST_EN
    logic [IDX_W-1:0] start_q;

    assign grant_first      = grant_addr[OFF_W-1:1];
    assign start_idx        = start_q;
    assign early_word_valid = active && mem_data_valid && (recv_cnt == '0);
    assign unused_addr_bits = ^{i_miss_addr[0], d_miss_addr[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            start_q <= '0;
        else if (state == IDLE && grant_ok)
            start_q <= grant_first;
    end
`else
    assign grant_first      = '0;
    assign start_idx        = '0;
    assign unused_addr_bits = ^{i_miss_addr[OFF_W-1:0], d_miss_addr[OFF_W-1:0]};
`endif

    assign fill_we_i   = active && owner_i && mem_data_valid;
    assign fill_we_d   = active && owner_d && mem_data_valid;
    assign fill_idx    = start_idx + recv_cnt;
    assign fill_data   = mem_data_in;
    assign ICACHE_miss = i_miss_req && !fill_done_i;
    assign DCACHE_miss = d_miss_req && !fill_done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner_i     <= 1'b0;
            owner_d     <= 1'b0;
            issue_cnt   <= '0;
            recv_cnt    <= '0;
            base_hi     <= '0;
            mem_en      <= 1'b0;
            mem_addr    <= '0;
            fill_done_i <= 1'b0;
            fill_done_d <= 1'b0;
        end else begin
            fill_done_i <= 1'b0;
            fill_done_d <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        owner_d   <= d_miss_req;
                        owner_i   <= !d_miss_req;
                        base_hi   <= grant_addr[ADDR_W-1:OFF_W];
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        mem_en    <= 1'b1;
                        mem_addr  <= {grant_addr[ADDR_W-1:OFF_W], grant_first, 1'b0};
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_cnt == LAST_IDX) begin
                        mem_en <= 1'b0;
                        state  <= DRAIN;
                    end else begin
                        issue_cnt <= next_issue;
                        mem_addr  <= {base_hi, start_idx + next_issue, 1'b0};
                    end
                end
                DRAIN: ;
                default: state <= IDLE;
            endcase

            if (active && mem_data_valid) begin
                recv_cnt <= recv_cnt + ONE_IDX;
                if (recv_cnt == LAST_IDX) begin
                    fill_done_i <= owner_i;
                    fill_done_d <= owner_d;
                    owner_i     <= 1'b0;
                    owner_d     <= 1'b0;
                    mem_en      <= 1'b0;
                    state       <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a fixed 4-cycle memory model.
// Follows CACHE_FILL_CRITICAL_FIRST_EN when defined.
module tb_cache_fill_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int WPB = 8;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_miss_req, d_miss_req;
    logic [AW-1:0] i_miss_addr, d_miss_addr;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic          mem_data_valid;
    logic [DW-1:0] mem_data_in;
    logic          fill_we_i, fill_we_d;
    logic [2:0]    fill_idx;
    logic [DW-1:0] fill_data;
    logic          fill_done_i, fill_done_d;
    logic          ICACHE_miss, DCACHE_miss;
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
    logic          early_word_valid;
`endif

    int checks = 0;
    int errors = 0;

    cache_fill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_BLOCK(WPB)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_miss_req     (i_miss_req),
        .i_miss_addr    (i_miss_addr),
        .d_miss_req     (d_miss_req),
        .d_miss_addr    (d_miss_addr),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_data_valid (mem_data_valid),
        .mem_data_in    (mem_data_in),
        .fill_we_i      (fill_we_i),
        .fill_we_d      (fill_we_d),
        .fill_idx       (fill_idx),
        .fill_data      (fill_data),
        .fill_done_i    (fill_done_i),
        .fill_done_d    (fill_done_d),
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
        .early_word_valid (early_word_valid),
`endif
        .ICACHE_miss    (ICACHE_miss),
        .DCACHE_miss    (DCACHE_miss)
    );

    always #5 clk = ~clk;

    // Memory model: not reset, so words issued before a reset still come back.
    logic [LAT-1:0] pv = '0;
    logic [AW-1:0]  pa [LAT];
    always @(posedge clk) begin
        pv    <= {pv[LAT-2:0], mem_en};
        pa[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
    end
    assign mem_data_valid = pv[LAT-1];
    assign mem_data_in    = pa[LAT-1] ^ 16'h5A5A;

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Call at the negedge of the grant cycle; returns at the negedge of the done-pulse cycle.
    task automatic fill_check(input bit side_d, input logic [15:0] req_addr,
                              input int raise_d_at, input logic [15:0] raise_addr);
        logic [15:0] base;
        int          start;
        int          k;
        logic [15:0] a;
        bit          rx, last;
        base  = {req_addr[15:4], 4'h0};
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
        start = int'(req_addr[3:1]);
`else
        start = 0;
`endif
        for (int t = 1; t <= WPB + LAT + 1; t++) begin
            @(negedge clk);
            last = (t == WPB + LAT + 1);
            chk("mem_en", mem_en, t <= WPB);
            if (t <= WPB) begin
                a = base + 16'(2 * ((start + t - 1) % WPB));
                chk("mem_addr", mem_addr, a);
            end
            rx = (t > LAT) && (t <= WPB + LAT);
            k  = t - LAT - 1;
            chk("fill_we_i", fill_we_i, rx && !side_d);
            chk("fill_we_d", fill_we_d, rx && side_d);
            if (rx) begin
                a = base + 16'(2 * ((start + k) % WPB));
                chk("fill_idx", fill_idx, (start + k) % WPB);
                chk("fill_data", fill_data, mdata(a));
            end
            chk("fill_done_i", fill_done_i, last && !side_d);
            chk("fill_done_d", fill_done_d, last && side_d);
            chk("ICACHE_miss", ICACHE_miss, i_miss_req && !(last && !side_d));
            chk("DCACHE_miss", DCACHE_miss, d_miss_req && !(last && side_d));
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
            chk("early_word_valid", early_word_valid, t == LAT + 1);
`endif
            if (t == raise_d_at) begin
                d_miss_addr = raise_addr;
                d_miss_req  = 1'b1;
            end
            if (last) begin
                if (side_d) d_miss_req = 1'b0;
                else        i_miss_req = 1'b0;
            end
        end
    endtask

    initial begin
        int stale;
        rst = 1'b1;
        i_miss_req = 1'b0; d_miss_req = 1'b0;
        i_miss_addr = '0;  d_miss_addr = '0;
        repeat (2) @(negedge clk);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_done_i", fill_done_i, 0);
        chk("rst_done_d", fill_done_d, 0);
        chk("rst_we_i", fill_we_i, 0);
        rst = 1'b0;
        @(negedge clk);

        // single I miss
        i_miss_addr = 16'h0134; i_miss_req = 1'b1;
        #1 chk("imiss_stall_on", ICACHE_miss, 1);
        fill_check(1'b0, 16'h0134, 0, 16'h0);

        // simultaneous D and I: D first, I granted after fill_done_d
        @(negedge clk);
        d_miss_addr = 16'h2000; i_miss_addr = 16'h0040;
        d_miss_req = 1'b1; i_miss_req = 1'b1;
        fill_check(1'b1, 16'h2000, 0, 16'h0);
        @(negedge clk);
        chk("gap_mem_en", mem_en, 0);
        chk("gap_icache_miss", ICACHE_miss, 1);
        fill_check(1'b0, 16'h0040, 0, 16'h0);

        // D arrives 3 cycles into an I fill, no preemption
        @(negedge clk);
        i_miss_addr = 16'h0456; i_miss_req = 1'b1;
        fill_check(1'b0, 16'h0456, 3, 16'h0A10);
        @(negedge clk);
        chk("wait_mem_en", mem_en, 0);
        chk("wait_dcache_miss", DCACHE_miss, 1);
        fill_check(1'b1, 16'h0A10, 0, 16'h0);

        // reset in cycle 5 of a fill
        @(negedge clk);
        i_miss_addr = 16'h0300; i_miss_req = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_rst_we_i", fill_we_i, 1);
        rst = 1'b1; i_miss_req = 1'b0;
        #1;
        chk("abort_mem_en", mem_en, 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_we_i", fill_we_i, 0);
        chk("abort_idx", fill_idx, 0);
        chk("abort_done_i", fill_done_i, 0);
        chk("abort_icache_miss", ICACHE_miss, 0);
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            stale += int'(mem_data_valid);
            chk("stale_we_i", fill_we_i, 0);
            chk("stale_we_d", fill_we_d, 0);
            chk("stale_mem_en", mem_en, 0);
        end
        chk("stale_words_seen", stale, 3);

        // recovery after abort
        @(negedge clk);
        i_miss_addr = 16'h0F22; i_miss_req = 1'b1;
        fill_check(1'b0, 16'h0F22, 0, 16'h0);

        // D miss at a mid-block word (critical-first order when enabled)
        @(negedge clk);
        d_miss_addr = 16'h100A; d_miss_req = 1'b1;
        fill_check(1'b1, 16'h100A, 0, 16'h0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
